pu_or1k_true_dpram_be: RTL and testbench
========================================

Name: pu_or1k_true_dpram_be

Overview:
Single-clock true dual-port RAM with per-byte write enables, request/valid handshakes on both ports, and an optional output pipeline register. It resolves same-address collisions deterministically and counts them. It is the generalised memory primitive for the PU-OR1K caches and scratchpads: two independent CPU/DMA-side ports share one array.

Parameters:
ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8
OUT_REG, 0, 0 = read latency 1; 1 = extra output register stage, latency 2
WRITE_FIRST, 1, own-port data on a write: 1 = newly merged word; 0 = old word
RDW_NEW, 0, cross-port read of an address written in the same cycle: 1 = merged new word; 0 = old word

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active low
a_req  in  1  port A request; accepted every cycle it is high (always ready)
a_we  in  1  port A write (1) / read (0)
a_be  in  DATA_WIDTH/8  port A byte enables, used on writes only
a_addr  in  ADDR_WIDTH  port A word address
a_din  in  DATA_WIDTH  port A write data
a_dout  out  DATA_WIDTH  port A read data
a_valid  out  1  port A response strobe
b_req, b_we, b_be, b_addr, b_din, b_dout, b_valid  as port A, for port B
collision  out  1  one-cycle pulse on a write-write byte overlap
collision_cnt  out  16  saturating count of collision pulses

Behaviour:
- Reset: rst_n is asynchronous, active low. While rst_n=0, outputs a_dout/b_dout=0, a_valid/b_valid=0, collision=0, collision_cnt=0, and all pipeline stages are cleared.
- Memory contents are not reset. Requests presented while rst_n=0 are dropped, and writes during reset do not modify the array.
- Write: at the clk edge where req=1 and we=1, only the bytes whose be bit is 1 are updated. be=0 on all bytes gives a no-op write that still returns a response.
- Read: req=1 and we=0 returns mem[addr] as sampled at that edge.
- Latency: valid rises exactly 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after the accepting edge, for reads and writes alike. Back-to-back requests give back-to-back valids.
- dout holds its last value whenever valid=0.
- Own-port write response: with WRITE_FIRST=1, dout is the old word with the enabled bytes replaced by din. With WRITE_FIRST=0, dout is the pre-write word.
- Same address, both ports write: the bytes enabled on only one port take that port's data. Overlapping enabled bytes take port A's data (A wins). If at least one byte overlaps, collision pulses high for 1 cycle, aligned with the valids of the colliding requests, and collision_cnt increments, saturating at 16'hFFFF.
- Same address, one port writes and the other reads: the reader gets the merged new word if RDW_NEW=1, otherwise the old word. No collision pulse.
- Same address, both ports read: both ports return the same data. No collision.
- Different addresses: the ports are fully independent.
- Reset mid-operation: in-flight responses are discarded (valid stays 0). A write accepted on the edge before reset assertion has already completed.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles with a_req=1, a_we=1, addr 0x10, din 0xDEADBEEF. After release, read addr 0x10 -> a_valid 1 cycle later and the word is not 0xDEADBEEF (or equals the preloaded value); collision_cnt=0.
- Byte-enable write: write 0x11223344 to addr 5 with be=4'hF, then write 0xAABBCCDD with be=4'b0101, then read -> dout=0x11BB33DD. With OUT_REG=1, a_valid rises 2 cycles after each request.
- Write-write collision at addr 7: A writes 0xAAAAAAAA with be=4'b0011, B writes 0xBBBBBBBB with be=4'b0110 -> stored word 0x00BBAAAA over a prior 0x00000000. collision pulses once and collision_cnt=1.
- Read-during-write at addr 3 (prior value 0x12345678): A writes 0xCAFEF00D with be=F while B reads -> b_dout=0x12345678 (RDW_NEW=0) or 0xCAFEF00D (RDW_NEW=1). With WRITE_FIRST=0, a_dout=0x12345678.
- Streaming: 256 back-to-back reads on A while B writes a disjoint range -> a_valid high for 256 consecutive cycles with correct data and no collisions.
- Saturation: force 65 540 write-write collisions -> collision_cnt stays at 0xFFFF. Then assert rst_n=0 -> collision_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pu_or1k_true_dpram_be.sv
// Single-clock true dual-port RAM with byte enables, fixed-latency responses
// and deterministic same-address collision resolution (port A wins overlaps).
module pu_or1k_true_dpram_be #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_REG     = 0,
    parameter int WRITE_FIRST = 1,
    parameter int RDW_NEW     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    output logic                    a_valid,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_din,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_valid,
    output logic                    collision,
    output logic [15:0]             collision_cnt
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Handshake: a request is accepted on every rising edge where req=1 and
    // rst_n=1 (ports are always ready); valid pulses once per accepted request
    // a fixed 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles later, dout holds otherwise.

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_wen, b_wen, same, collide;
    logic [DATA_WIDTH-1:0] old_a, old_b, own_a, own_b, new_a, new_b;
    logic [DATA_WIDTH-1:0] a_rsp, b_rsp;

    always_comb begin
        a_wen = rst_n & a_req & a_we;
        b_wen = rst_n & b_req & b_we;
        same  = a_req & b_req & (a_addr == b_addr);
        old_a = mem[a_addr];
        old_b = mem[b_addr];
        own_a = old_a;
        own_b = old_b;
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (a_be[i]) own_a[i*8 +: 8] = a_din[i*8 +: 8];
            if (b_be[i]) own_b[i*8 +: 8] = b_din[i*8 +: 8];
            // Both merged words agree on a shared address, so writing both is safe.
            if (a_wen && a_be[i])
                new_a[i*8 +: 8] = a_din[i*8 +: 8];
            else if (same && b_wen && b_be[i])
                new_a[i*8 +: 8] = b_din[i*8 +: 8];
            if (same && a_wen && a_be[i])
                new_b[i*8 +: 8] = a_din[i*8 +: 8];
            else if (b_wen && b_be[i])
                new_b[i*8 +: 8] = b_din[i*8 +: 8];
        end
        collide = same & a_wen & b_wen & (|(a_be & b_be));
    end

    always_comb begin
        a_rsp = old_a;
        b_rsp = old_b;
        if (a_we)
            a_rsp = (WRITE_FIRST != 0) ? own_a : old_a;
        else if (same && b_we && (RDW_NEW != 0))
            a_rsp = new_b;
        if (b_we)
            b_rsp = (WRITE_FIRST != 0) ? own_b : old_b;
        else if (same && a_we && (RDW_NEW != 0))
            b_rsp = new_a;
    end

    always_ff @(posedge clk) begin
        if (a_wen) mem[a_addr] <= new_a;
        if (b_wen) mem[b_addr] <= new_b;
    end

    logic                  a_v1, b_v1, c1, col_load;
    logic [DATA_WIDTH-1:0] a_d1, b_d1;
    logic [15:0]           cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
            c1   <= 1'b0;
            a_d1 <= '0;
            b_d1 <= '0;
        end else begin
            a_v1 <= a_req;
            b_v1 <= b_req;
            c1   <= collide;
            if (a_req) a_d1 <= a_rsp;
            if (b_req) b_d1 <= b_rsp;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  a_v2, b_v2, c2;
            logic [DATA_WIDTH-1:0] a_d2, b_d2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                    c2   <= 1'b0;
                    a_d2 <= '0;
                    b_d2 <= '0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    c2   <= c1;
                    if (a_v1) a_d2 <= a_d1;
                    if (b_v1) b_d2 <= b_d1;
                end
            end
            assign a_valid   = a_v2;
            assign b_valid   = b_v2;
            assign a_dout    = a_d2;
            assign b_dout    = b_d2;
            assign collision = c2;
            assign col_load  = c1;
        end else begin : g_no_out_reg
            assign a_valid   = a_v1;
            assign b_valid   = b_v1;
            assign a_dout    = a_d1;
            assign b_dout    = b_d1;
            assign collision = c1;
            assign col_load  = collide;
        end
    endgenerate

    // The count steps on the same edge the collision pulse is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (col_load && (cnt != 16'hFFFF))
            cnt <= cnt + 16'd1;
    end

    assign collision_cnt = cnt;

endmodule

// File: tb/tb_pu_or1k_true_dpram_be.sv
// Randomised and directed checks of pu_or1k_true_dpram_be against a
// byte-level reference model and a response scoreboard.
module tb_pu_or1k_true_dpram_be;
    localparam int AW          = 10;
    localparam int DW          = 32;
    localparam int NB          = DW / 8;
    localparam int OUT_REG     = 0;
    localparam int WRITE_FIRST = 1;
    localparam int RDW_NEW     = 0;
    localparam int LAT         = (OUT_REG != 0) ? 2 : 1;

    logic          clk, rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [NB-1:0] a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din, a_dout, b_dout;
    logic          a_valid, b_valid, collision;
    logic [15:0]   collision_cnt;

    pu_or1k_true_dpram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(OUT_REG),
        .WRITE_FIRST(WRITE_FIRST), .RDW_NEW(RDW_NEW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_valid(a_valid),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout), .b_valid(b_valid),
        .collision(collision), .collision_cnt(collision_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: {collision flag, data} per expected response
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW:0]   exp_a_q[$];
    logic [DW:0]   exp_b_q[$];
    int            model_cnt = 0;

    function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old,
                                               input logic [DW-1:0] din,
                                               input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++)
            if (be[i]) r[i*8 +: 8] = din[i*8 +: 8];
        return r;
    endfunction

    logic [DW-1:0] m_old_a, m_old_b, m_ra, m_rb;
    logic          m_hit, m_col;

    always @(posedge clk) begin
        if (rst_n) begin
            m_old_a = ref_mem[a_addr];
            m_old_b = ref_mem[b_addr];
            m_hit   = a_req && b_req && (a_addr == b_addr);
            m_col   = m_hit && a_we && b_we && ((a_be & b_be) != '0);
            // B's write first, then A's on top: A wins overlapping bytes
            if (b_req && b_we) ref_mem[b_addr] = apply_be(ref_mem[b_addr], b_din, b_be);
            if (a_req && a_we) ref_mem[a_addr] = apply_be(ref_mem[a_addr], a_din, a_be);
            if (a_we)
                m_ra = (WRITE_FIRST != 0) ? apply_be(m_old_a, a_din, a_be) : m_old_a;
            else
                m_ra = (m_hit && b_we && RDW_NEW != 0) ? ref_mem[a_addr] : m_old_a;
            if (b_we)
                m_rb = (WRITE_FIRST != 0) ? apply_be(m_old_b, b_din, b_be) : m_old_b;
            else
                m_rb = (m_hit && a_we && RDW_NEW != 0) ? ref_mem[b_addr] : m_old_b;
            if (a_req) exp_a_q.push_back({m_col, m_ra});
            if (b_req) exp_b_q.push_back({m_col, m_rb});
            if (m_col && model_cnt < 65535) model_cnt++;
        end
    end

    always @(negedge rst_n) begin
        exp_a_q.delete();
        exp_b_q.delete();
        model_cnt = 0;
    end

    // scoreboard / monitor
    int          run = 0, max_run = 0, col_pulses = 0;
    logic [DW:0] e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (collision) col_pulses++;
            if (a_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (exp_a_q.size() == 0) check("a_extra_valid", 1, 0);
                else begin
                    e = exp_a_q.pop_front();
                    check("a_dout", a_dout, e[DW-1:0]);
                    check("a_collision", {31'd0, collision}, {31'd0, e[DW]});
                end
            end else begin
                run = 0;
                if (collision) check("stray_collision", 1, 0);
            end
            if (b_valid) begin
                if (exp_b_q.size() == 0) check("b_extra_valid", 1, 0);
                else begin
                    e = exp_b_q.pop_front();
                    check("b_dout", b_dout, e[DW-1:0]);
                    check("b_collision", {31'd0, collision}, {31'd0, e[DW]});
                end
            end
        end
    end

    // driver tasks
    task automatic set_a(input logic req, input logic we, input logic [NB-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] din);
        a_req = req; a_we = we; a_be = be; a_addr = addr; a_din = din;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [NB-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] din);
        b_req = req; b_we = we; b_be = be; b_addr = addr; b_din = din;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    // cycles from the accepting edge to valid, bounded
    task automatic wait_valid(input bit port_b, output int lat);
        lat = 1;
        while (!(port_b ? b_valid : a_valid) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_valid"}, {31'd0, a_valid}, 0);
        check({tag, "_b_valid"}, {31'd0, b_valid}, 0);
        check({tag, "_a_dout"}, a_dout, 0);
        check({tag, "_b_dout"}, b_dout, 0);
        check({tag, "_collision"}, {31'd0, collision}, 0);
        check({tag, "_cnt"}, {16'd0, collision_cnt}, 0);
    endtask

    int lat;

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        check_reset_outputs("rst0");
        #2 rst_n = 1'b1;
        tick();

        // preload every word with random data
        for (int i = 0; i < 512; i++) begin
            set_a(1'b1, 1'b1, '1, AW'(i), $urandom);
            set_b(1'b1, 1'b1, '1, AW'(i + 512), $urandom);
            tick();
        end
        drain();

        // writes during reset must be dropped
        #2 rst_n = 1'b0;
        set_a(1'b1, 1'b1, '1, 10'h010, 32'hDEADBEEF);
        repeat (3) tick();
        check_reset_outputs("rst1");
        idle();
        #2 rst_n = 1'b1;
        tick();
        set_a(1'b1, 1'b0, '0, 10'h010, '0);
        tick();
        idle();
        wait_valid(1'b0, lat);
        check("rst_rd_lat", lat, LAT);
        check("rst_rd_data", a_dout, ref_mem[16]);
        check("rst_rd_not_dead", {31'd0, a_dout == 32'hDEADBEEF}, 0);
        check("rst_rd_cnt", {16'd0, collision_cnt}, 0);
        drain();

        // byte-enable merge at addr 5
        set_a(1'b1, 1'b1, 4'hF, 10'd5, 32'h11223344);
        tick(); idle(); wait_valid(1'b0, lat);
        check("be_wr1_lat", lat, LAT);
        set_a(1'b1, 1'b1, 4'b0101, 10'd5, 32'hAABBCCDD);
        tick(); idle(); wait_valid(1'b0, lat);
        check("be_wr2_lat", lat, LAT);
        set_a(1'b1, 1'b0, '0, 10'd5, '0);
        tick(); idle(); wait_valid(1'b0, lat);
        check("be_rd_lat", lat, LAT);
        check("be_rd_data", a_dout, 32'h11BB33DD);
        drain();

        // write-write collision at addr 7
        col_pulses = 0;
        set_a(1'b1, 1'b1, 4'hF, 10'd7, 32'h0);
        tick();
        set_a(1'b1, 1'b1, 4'b0011, 10'd7, 32'hAAAAAAAA);
        set_b(1'b1, 1'b1, 4'b0110, 10'd7, 32'hBBBBBBBB);
        tick();
        drain();
        set_b(1'b1, 1'b0, '0, 10'd7, '0);
        tick(); idle(); wait_valid(1'b1, lat);
        check("ww_rd_data", b_dout, 32'h00BBAAAA);
        check("ww_pulses", col_pulses, 1);
        check("ww_cnt", {16'd0, collision_cnt}, 1);
        drain();

        // read-during-write at addr 3
        set_a(1'b1, 1'b1, 4'hF, 10'd3, 32'h12345678);
        tick();
        set_a(1'b1, 1'b1, 4'hF, 10'd3, 32'hCAFEF00D);
        set_b(1'b1, 1'b0, '0, 10'd3, '0);
        tick(); idle(); wait_valid(1'b1, lat);
        check("rdw_lat", lat, LAT);
        check("rdw_b_data", b_dout, (RDW_NEW != 0) ? 32'hCAFEF00D : 32'h12345678);
        check("rdw_a_data", a_dout, (WRITE_FIRST != 0) ? 32'hCAFEF00D : 32'h12345678);
        drain();

        // random traffic in a small window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 7)), $urandom);
            set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 7)), $urandom);
            tick();
        end
        drain();
        check("rand_cnt", {16'd0, collision_cnt}, model_cnt);

        // streaming reads on A, disjoint writes on B
        max_run = 0;
        for (int i = 0; i < 256; i++) begin
            set_a(1'b1, 1'b0, '0, AW'(i), '0);
            set_b(1'b1, 1'b1, NB'($urandom_range(0, 15)), AW'(i + 512), $urandom);
            tick();
        end
        drain();
        check("stream_run", max_run, 256);
        check("stream_cnt", {16'd0, collision_cnt}, model_cnt);

        // counter saturation
        for (int i = 0; i < 65540; i++) begin
            set_a(1'b1, 1'b1, '1, 10'd9, $urandom);
            set_b(1'b1, 1'b1, '1, 10'd9, $urandom);
            tick();
        end
        drain();
        check("sat_cnt", {16'd0, collision_cnt}, 32'h0000FFFF);
        check("a_q_empty", exp_a_q.size(), 0);
        check("b_q_empty", exp_b_q.size(), 0);

        // asynchronous clear, no clock edge in between
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
